// File: rtl/decoder_param.sv
// decoder_param: registered one-hot decoder with a self-scan sweep mode.
// Define DECODER_ERRCNT_EN to add the saturating out-of-range counter o_err_cnt.
module decoder_param #(
  parameter int IN_W      = 4,
  parameter int OUT_N     = 10,
  parameter int SCAN_HOLD = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [IN_W-1:0]  i_data,
  input  logic             i_mode,
  output logic [OUT_N-1:0] o_decode,
  output logic             o_valid,
  output logic             o_err,
  output logic             o_scan_done
`ifdef DECODER_ERRCNT_EN
  ,
  output logic [7:0]       o_err_cnt
`endif
);
  localparam int SW = $clog2(OUT_N + 1);
  localparam int HW = $clog2(SCAN_HOLD + 1);
  typedef enum logic [1:0] {IDLE, DECODE, SCAN, DONE} state_t;
  state_t state, state_nx;
  logic [SW-1:0] scan_cnt, scan_nx;
  logic [HW-1:0] hold_cnt, hold_nx;
  logic [OUT_N-1:0] one, dec_nx;
  logic valid_nx, err_nx, done_nx, oor, last_hold, sweep_end;
  assign one       = {{(OUT_N-1){1'b0}}, 1'b1};
  assign oor       = 32'(i_data) >= OUT_N;
  assign last_hold = hold_cnt == HW'(SCAN_HOLD - 1);
  // scan_cnt reaching OUT_N means the final code has already been held
  assign sweep_end = scan_cnt == SW'(OUT_N);
  always_comb begin
    state_nx = state;
    scan_nx  = scan_cnt;
    hold_nx  = hold_cnt;
    dec_nx   = o_decode;
    err_nx   = o_err;
    valid_nx = 1'b0;
    done_nx  = 1'b0;
    case (state)
      IDLE, DECODE: begin
        if (i_mode) begin
          state_nx = SCAN;
          scan_nx  = '0;
          hold_nx  = '0;
        end else if (i_valid) begin
          state_nx = DECODE;
          dec_nx   = oor ? '0 : one << i_data;
          err_nx   = oor;
          valid_nx = 1'b1;
        end else
          state_nx = IDLE;
      end
      SCAN: begin
        if (!i_mode)
          state_nx = IDLE;
        else if (sweep_end) begin
          state_nx = DONE;
          done_nx  = 1'b1;
        end else begin
          dec_nx   = one << scan_cnt;
          err_nx   = 1'b0;
          valid_nx = 1'b1;
          hold_nx  = last_hold ? '0 : hold_cnt + 1'b1;
          scan_nx  = scan_cnt + SW'(last_hold);
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state       <= IDLE;
      scan_cnt    <= '0;
      hold_cnt    <= '0;
      o_decode    <= '0;
      o_valid     <= 1'b0;
      o_err       <= 1'b0;
      o_scan_done <= 1'b0;
    end else begin
      state       <= state_nx;
      scan_cnt    <= scan_nx;
      hold_cnt    <= hold_nx;
      o_decode    <= dec_nx;
      o_valid     <= valid_nx;
      o_err       <= err_nx;
      o_scan_done <= done_nx;
    end
`ifdef DECODER_ERRCNT_EN
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n)
      o_err_cnt <= '0;
    else if (valid_nx && err_nx && o_err_cnt != 8'hff)
      o_err_cnt <= o_err_cnt + 8'd1;
`endif
endmodule

// File: tb/tb_decoder_param.sv
// tb_decoder_param: scenario tasks checked against spec-level expectations.
module tb_decoder_param;
  localparam int N = 10;
  localparam int H = 2;
  logic i_clk = 0, i_rst_n = 0, i_valid = 0, i_mode = 0;
  logic [3:0] i_data = '0;
  logic [N-1:0] o_decode;
  logic o_valid, o_err, o_scan_done;
  logic [7:0] s_decode;
  logic s_valid, s_err, s_done;
  logic [N-1:0] exp_dec = '0;
  logic exp_err = 0;
  int n_cmp = 0, n_bad = 0, exp_cnt = 0;
`ifdef DECODER_ERRCNT_EN
  logic [7:0] o_err_cnt, s_err_cnt;
`endif

  always #5 i_clk = ~i_clk;

  decoder_param #(.IN_W(4), .OUT_N(N), .SCAN_HOLD(H)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_data(i_data), .i_mode(i_mode),
    .o_decode(o_decode), .o_valid(o_valid), .o_err(o_err), .o_scan_done(o_scan_done)
`ifdef DECODER_ERRCNT_EN
    , .o_err_cnt(o_err_cnt)
`endif
  );

  decoder_param #(.IN_W(3), .OUT_N(8), .SCAN_HOLD(1)) u_small (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_data(i_data[2:0]), .i_mode(i_mode),
    .o_decode(s_decode), .o_valid(s_valid), .o_err(s_err), .o_scan_done(s_done)
`ifdef DECODER_ERRCNT_EN
    , .o_err_cnt(s_err_cnt)
`endif
  );

  function automatic logic [N-1:0] ref_dec(int d);
    return (d < N) ? (N'(1) << d) : '0;
  endfunction

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset;
    i_rst_n = 0; i_valid = 1; i_data = 4'd3; i_mode = 0;
    repeat (2) @(posedge i_clk);
    #1;
    n_cmp++;
    if ({o_valid, o_err, o_scan_done, o_decode} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got v=%b e=%b d=%b dec=%h want all 0", o_valid, o_err, o_scan_done, o_decode);
    end
`ifdef DECODER_ERRCNT_EN
    n_cmp++;
    if (o_err_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_errcnt: got %0d want 0", o_err_cnt); end
`endif
    i_rst_n = 1;
    tick;
    exp_dec = ref_dec(3); exp_err = 0; exp_cnt = 0;
    n_cmp++;
    if ({o_valid, o_err, o_decode} !== {1'b1, 1'b0, exp_dec}) begin
      n_bad++; $display("FAIL first_after_reset: got v=%b dec=%h want v=1 dec=%h", o_valid, o_decode, exp_dec);
    end
    i_valid = 0;
    tick;
  endtask

  task automatic test_decode_sweep;
    for (int d = 0; d < N; d++) begin
      i_valid = 1; i_data = 4'(d);
      tick;
      exp_dec = ref_dec(d);
      n_cmp++;
      if ({o_valid, o_err, o_scan_done, o_decode} !== {3'b100, exp_dec}) begin
        n_bad++; $display("FAIL sweep code=%0d: got v=%b e=%b dec=%h want v=1 e=0 dec=%h", d, o_valid, o_err, o_decode, exp_dec);
      end
    end
    i_valid = 0; i_data = 4'($urandom);
    tick;
    n_cmp++;
    if ({o_valid, o_err, o_decode} !== {2'b00, exp_dec}) begin
      n_bad++; $display("FAIL sweep_hold: got v=%b dec=%h want v=0 dec=%h", o_valid, o_decode, exp_dec);
    end
  endtask

  task automatic test_out_of_range;
    for (int d = N; d < 16; d++) begin
      i_valid = 1; i_data = 4'(d);
      tick;
      exp_dec = '0; exp_err = 1; exp_cnt++;
      n_cmp++;
      if ({o_valid, o_err, o_decode} !== {2'b11, exp_dec}) begin
        n_bad++; $display("FAIL oor code=%0d: got v=%b e=%b dec=%h want v=1 e=1 dec=0", d, o_valid, o_err, o_decode);
      end
    end
    i_valid = 0;
    tick;
    n_cmp++;
    if ({o_valid, o_err} !== 2'b01) begin
      n_bad++; $display("FAIL oor_hold: got v=%b e=%b want v=0 e=1", o_valid, o_err);
    end
`ifdef DECODER_ERRCNT_EN
    n_cmp++;
    if (o_err_cnt !== 8'(exp_cnt)) begin n_bad++; $display("FAIL oor_errcnt: got %0d want %0d", o_err_cnt, exp_cnt); end
`endif
  endtask

  task automatic test_random;
    for (int c = 0; c < 300; c++) begin
      logic v;
      int d;
      v = 1'($urandom_range(0, 1)); d = $urandom_range(0, 15);
      i_valid = v; i_data = 4'(d);
      tick;
      if (v) begin
        exp_dec = ref_dec(d); exp_err = (d >= N);
        if (d >= N && exp_cnt < 255) exp_cnt++;
      end
      n_cmp++;
      if ({o_valid, o_err, o_scan_done, o_decode} !== {v, exp_err, 1'b0, exp_dec}) begin
        n_bad++; $display("FAIL random c=%0d d=%0d v=%b: got v=%b e=%b sd=%b dec=%h want e=%b dec=%h", c, d, v, o_valid, o_err, o_scan_done, o_decode, exp_err, exp_dec);
      end
    end
    i_valid = 0;
    tick;
`ifdef DECODER_ERRCNT_EN
    n_cmp++;
    if (o_err_cnt !== 8'(exp_cnt)) begin n_bad++; $display("FAIL random_errcnt: got %0d want %0d", o_err_cnt, exp_cnt); end
`endif
  endtask

  task automatic test_decode_to_scan;
    i_valid = 1; i_data = 4'd4;
    tick;
    exp_dec = ref_dec(4); exp_err = 0;
    i_mode = 1; i_valid = 1'($urandom);
    tick;
    n_cmp++;
    if ({o_valid, o_scan_done, o_decode} !== {2'b00, exp_dec}) begin
      n_bad++; $display("FAIL dec_to_scan_entry: got v=%b dec=%h want v=0 dec=%h", o_valid, o_decode, exp_dec);
    end
    tick;
    exp_dec = ref_dec(0);
    n_cmp++;
    if ({o_valid, o_err, o_decode} !== {2'b10, exp_dec}) begin
      n_bad++; $display("FAIL dec_to_scan_first: got v=%b e=%b dec=%h want v=1 e=0 dec=%h", o_valid, o_err, o_decode, exp_dec);
    end
    i_mode = 0; i_valid = 0;
    tick;
  endtask

  task automatic test_priority;
    i_mode = 1; i_valid = 1; i_data = 4'd7;
    tick;
    i_mode = 0; i_valid = 0;
    tick;
    n_cmp++;
    if ({o_valid, o_scan_done, o_decode} !== {2'b00, exp_dec}) begin
      n_bad++; $display("FAIL priority_dropped: got v=%b dec=%h want v=0 dec=%h", o_valid, o_decode, exp_dec);
    end
  endtask

  task automatic test_abort;
    i_mode = 1;
    tick;
    for (int k = 0; k < 4; k++) begin
      tick;
      exp_dec = ref_dec(k / H);
      n_cmp++;
      if ({o_valid, o_decode} !== {1'b1, exp_dec}) begin
        n_bad++; $display("FAIL abort_scan k=%0d: got v=%b dec=%h want v=1 dec=%h", k, o_valid, o_decode, exp_dec);
      end
    end
    i_mode = 0;
    for (int k = 0; k < 3; k++) begin
      tick;
      n_cmp++;
      if ({o_valid, o_scan_done, o_decode} !== {2'b00, exp_dec}) begin
        n_bad++; $display("FAIL abort_idle k=%0d: got v=%b sd=%b dec=%h want v=0 sd=0 dec=%h", k, o_valid, o_scan_done, o_decode, exp_dec);
      end
    end
    i_valid = 1; i_data = 4'd6;
    tick;
    exp_dec = ref_dec(6);
    n_cmp++;
    if ({o_valid, o_decode} !== {1'b1, exp_dec}) begin
      n_bad++; $display("FAIL abort_then_decode: got v=%b dec=%h want v=1 dec=%h", o_valid, o_decode, exp_dec);
    end
    i_valid = 0;
    tick;
  endtask

  task automatic test_scan;
    int w;
    i_mode = 1;
    tick;
    n_cmp++;
    if (o_valid !== 1'b0) begin n_bad++; $display("FAIL scan_entry: got v=%b want 0", o_valid); end
    for (int k = 0; k < N * H; k++) begin
      i_valid = 1'($urandom); i_data = 4'($urandom);
      tick;
      exp_dec = ref_dec(k / H);
      n_cmp++;
      if ({o_valid, o_err, o_scan_done, o_decode} !== {3'b100, exp_dec}) begin
        n_bad++; $display("FAIL scan k=%0d: got v=%b e=%b sd=%b dec=%h want v=1 e=0 sd=0 dec=%h", k, o_valid, o_err, o_scan_done, o_decode, exp_dec);
      end
    end
    i_valid = 0;
    tick;
    n_cmp++;
    if ({o_valid, o_scan_done} !== 2'b01) begin
      n_bad++; $display("FAIL scan_done: got v=%b sd=%b want v=0 sd=1", o_valid, o_scan_done);
    end
    tick;
    n_cmp++;
    if ({o_valid, o_scan_done} !== 2'b00) begin
      n_bad++; $display("FAIL scan_done_width: got v=%b sd=%b want v=0 sd=0", o_valid, o_scan_done);
    end
    w = 0;
    while (o_valid !== 1'b1 && w < 6) begin tick; w++; end
    exp_dec = ref_dec(0);
    n_cmp++;
    if ({o_valid, o_scan_done, o_decode} !== {2'b10, exp_dec}) begin
      n_bad++; $display("FAIL scan_restart: got v=%b sd=%b dec=%h after %0d cycles want v=1 dec=%h", o_valid, o_scan_done, o_decode, w, exp_dec);
    end
    i_mode = 0;
    tick;
  endtask

  task automatic test_reset_mid;
    i_mode = 1;
    repeat (6) tick;
    #3 i_rst_n = 0;
    #1;
    n_cmp++;
    if ({o_valid, o_err, o_scan_done, o_decode} !== '0) begin
      n_bad++; $display("FAIL reset_mid_async: got v=%b e=%b sd=%b dec=%h want all 0", o_valid, o_err, o_scan_done, o_decode);
    end
    tick;
    i_rst_n = 1; i_mode = 0; i_valid = 1; i_data = 4'd5;
    tick;
    exp_dec = ref_dec(5); exp_err = 0; exp_cnt = 0;
    n_cmp++;
    if ({o_valid, o_err, o_scan_done, o_decode} !== {3'b100, exp_dec}) begin
      n_bad++; $display("FAIL reset_mid_resume: got v=%b sd=%b dec=%h want v=1 sd=0 dec=%h", o_valid, o_scan_done, o_decode, exp_dec);
    end
    i_valid = 0;
    tick;
    n_cmp++;
    if ({o_valid, o_scan_done} !== 2'b00) begin
      n_bad++; $display("FAIL reset_mid_pulse: got v=%b sd=%b want 0 0", o_valid, o_scan_done);
    end
  endtask

  task automatic test_small;
    for (int d = 0; d < 8; d++) begin
      logic [7:0] e;
      e = 8'(1) << d;
      i_valid = 1; i_data = 4'(d);
      tick;
      n_cmp++;
      if ({s_valid, s_err, s_decode} !== {2'b10, e}) begin
        n_bad++; $display("FAIL small code=%0d: got v=%b e=%b dec=%h want v=1 e=0 dec=%h", d, s_valid, s_err, s_decode, e);
      end
    end
    i_valid = 0;
    tick;
  endtask

`ifdef DECODER_ERRCNT_EN
  task automatic test_err_saturate;
    i_valid = 1; i_data = 4'd15;
    repeat (260) tick;
    i_valid = 0;
    tick;
    n_cmp++;
    if (o_err_cnt !== 8'd255) begin n_bad++; $display("FAIL errcnt_saturate: got %0d want 255", o_err_cnt); end
  endtask
`endif

  initial begin
    test_reset;
    test_decode_sweep;
    test_out_of_range;
    test_random;
    test_decode_to_scan;
    test_priority;
    test_abort;
    test_scan;
    test_reset_mid;
    test_small;
`ifdef DECODER_ERRCNT_EN
    test_err_saturate;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/decoder_param.md
DECODER_PARAM -- requirements
Module: decoder_param

Interface
REQ-001 Parameter IN_W, default 4: input code width in bits, legal range 2..8.
REQ-002 Parameter OUT_N, default 10: one-hot output count, legal range 2..2**IN_W.
REQ-003 Parameter SCAN_HOLD, default 2: clock cycles each code is held in scan mode, range 1..255.
REQ-004 i_clk  input  1  single clock; all logic is rising-edge triggered.
REQ-005 i_rst_n  input  1  asynchronous active-low reset.
REQ-006 i_valid  input  1  i_data is qualified this cycle.
REQ-007 i_data  input  IN_W  binary code to decode.
REQ-008 i_mode  input  1  0 = normal decode, 1 = request self-scan.
REQ-009 o_decode  output  OUT_N  registered one-hot result; bit k is high for code k.
REQ-010 o_valid  output  1  o_decode and o_err are valid this cycle.
REQ-011 o_err  output  1  registered out-of-range flag for the accepted code.
REQ-012 o_scan_done  output  1  one-cycle pulse when a scan sweep completes.
REQ-013 o_err_cnt  output  8  saturating out-of-range count; present only with DECODER_ERRCNT_EN.

Function
REQ-014 The FSM SHALL have the states IDLE, DECODE, SCAN and DONE.
REQ-015 IDLE: if i_mode=1 go to SCAN, else if i_valid=1 go to DECODE, else stay in IDLE.
REQ-016 DECODE: register the result of i_data; o_valid=1 exactly one cycle after the i_valid cycle (latency 1).
REQ-017 Back-to-back i_valid in normal mode SHALL give one result per cycle with no bubble.
REQ-018 i_data < OUT_N: o_decode = 1 << i_data, o_err = 0.
REQ-019 i_data >= OUT_N: o_decode = all zeros, o_err = 1, o_valid = 1.
REQ-020 Cycles without a result: o_valid = 0; o_decode and o_err hold their last values.
REQ-021 SCAN: an internal counter steps 0..OUT_N-1; each code drives o_decode with o_valid=1 for SCAN_HOLD cycles.
REQ-022 The first scan code SHALL appear one cycle after SCAN is entered.
REQ-023 In SCAN, i_valid and i_data are ignored; o_err = 0.
REQ-024 After code OUT_N-1 has been held for SCAN_HOLD cycles, go to DONE.
REQ-025 DONE: o_scan_done = 1 for one cycle, o_valid = 0, then go to IDLE.
REQ-026 After DONE, a new sweep SHALL start only if i_mode is still 1 in IDLE.
REQ-027 If i_mode falls during SCAN, the sweep is aborted next cycle: go to IDLE, o_valid = 0, no o_scan_done.
REQ-028 If i_mode=1 and i_valid=1 arrive together in IDLE, scan SHALL win and the code is dropped.
REQ-029 If i_mode rises in DECODE, the in-flight result completes, then the FSM enters SCAN.
REQ-030 The scan counter SHALL wrap to 0 on every entry to SCAN.

Reset
REQ-031 While i_rst_n=0: state=IDLE, o_decode=0, o_valid=0, o_err=0, o_scan_done=0, o_err_cnt=0, scan counter=0, hold counter=0.
REQ-032 Reset mid-scan or mid-decode SHALL abandon the operation immediately, with no output pulse after release.
REQ-033 The first result SHALL be accepted on the first rising edge after reset release.

Configuration
REQ-034 Macro DECODER_ERRCNT_EN defined: o_err_cnt increments on each o_err=1 result and saturates at 255.
REQ-035 Macro DECODER_ERRCNT_EN undefined: the o_err_cnt port and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-036 Defaults; i_valid=1 with i_data stepping 0..9 every cycle -> o_decode 10'h001..10'h200 one cycle later, o_err=0 throughout.
REQ-037 i_data=10..15 with i_valid=1 -> o_decode=0, o_err=1; with DECODER_ERRCNT_EN, o_err_cnt=6.
REQ-038 i_mode=1 held, SCAN_HOLD=2 -> 20 o_valid cycles walking bit0..bit9, then o_scan_done for one cycle, then a new sweep starts.
REQ-039 i_mode dropped on the 5th scan cycle -> o_valid=0 the next cycle, no o_scan_done, FSM in IDLE.
REQ-040 i_rst_n pulsed low during a sweep -> all outputs 0 immediately; normal decode resumes on the first edge after release.
REQ-041 IN_W=3, OUT_N=8 -> codes 0..7 decode to 8'h01..8'h80 and o_err is never asserted.
